dvsd_prod_acc: RTL and testbench

- Downstream stage of the 8x8 multiplier: consumes its 16-bit products and accumulates them into frame sums (dot-product / MAC style).
- Valid/ready handshake on both sides.
- A frame closes on an explicit last flag or when NMAX products have been taken.
- Each closed frame is presented once with its product count and an overflow flag.

---
 rtl/dvsd_prod_acc.sv | 96 +++++++++
 tb/tb_dvsd_prod_acc.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dvsd_prod_acc.sv
// Product accumulator: sums unsigned products into frames closed by in_last or NMAX products.
// Optional saturation instead of wrap when DVSD_PROD_ACC_SAT_EN is defined.
module dvsd_prod_acc #(
  parameter int unsigned PW   = 16,
  parameter int unsigned AW   = 24,
  parameter int unsigned NMAX = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PW-1:0]              in_prod,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [AW-1:0]              out_sum,
  output logic [$clog2(NMAX+1)-1:0]  out_count,
  output logic                       out_ovf
);

  localparam int unsigned CW = $clog2(NMAX + 1);

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e        state;
  logic [AW-1:0] acc;
  logic [CW-1:0] count;
  logic          ovf;

  logic          accept;
  logic [AW:0]   sum_ext;
  logic [AW-1:0] acc_nxt;
  logic [CW-1:0] count_nxt;
  logic          ovf_nxt;
  logic          close;

  assign in_ready = ~rst & (state != StHold);
  assign accept   = in_valid & in_ready;

  // acc/count/ovf are zero in StIdle, so the same datapath serves the first product.
  always_comb begin
    sum_ext   = {1'b0, acc} + {1'b0, AW'(in_prod)};
    count_nxt = count + CW'(1);
    ovf_nxt   = ovf | sum_ext[AW];
`ifdef DVSD_PROD_ACC_SAT_EN
    // Once at all-ones, any nonzero add carries again, so saturation stays sticky.
    acc_nxt   = sum_ext[AW] ? {AW{1'b1}} : sum_ext[AW-1:0];
`else
    acc_nxt   = sum_ext[AW-1:0];
`endif
    close     = in_last | (count_nxt == CW'(NMAX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        StIdle, StAcc: begin
          if (accept) begin
            acc   <= acc_nxt;
            count <= count_nxt;
            ovf   <= ovf_nxt;
            if (close) begin
              state     <= StHold;
              out_valid <= 1'b1;
              out_sum   <= acc_nxt;
              out_count <= count_nxt;
              out_ovf   <= ovf_nxt;
            end else begin
              state <= StAcc;
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            state     <= StIdle;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dvsd_prod_acc.sv
// Directed table-driven bench for dvsd_prod_acc, plus hand sequences for NMAX close and
// overflow on a narrow (AW=16) instance.
module tb_dvsd_prod_acc;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_last, out_ready;
  logic [15:0] in_prod;

  logic        in_ready, out_valid, out_ovf;
  logic [23:0] out_sum;
  logic [4:0]  out_count;

  logic        in_ready2, out_valid2, out_ovf2;
  logic [15:0] out_sum2;
  logic [4:0]  out_count2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dvsd_prod_acc #(.PW(16), .AW(24), .NMAX(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  dvsd_prod_acc #(.PW(16), .AW(16), .NMAX(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_prod(in_prod),
    .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
    .out_count(out_count2), .out_ovf(out_ovf2)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [15:0] prod;
    logic        last;
    logic        ordy;
    logic        exp_ir;
    logic        exp_ov;
    logic [23:0] exp_sum;
    logic [4:0]  exp_cnt;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [15:0] p, input logic l,
                     input logic o, input logic ir, input logic ov, input logic [23:0] s,
                     input logic [4:0] c, input logic f);
    vec_t e;
    e.rst = r; e.valid = v; e.prod = p; e.last = l; e.ordy = o;
    e.exp_ir = ir; e.exp_ov = ov; e.exp_sum = s; e.exp_cnt = c; e.exp_ovf = f;
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [15:0] p, input logic l,
                       input logic o);
    rst = r; in_valid = v; in_prod = p; in_last = l; out_ready = o;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int idx, input logic ov,
                           input logic [23:0] s, input logic [4:0] c, input logic f);
    chk({tag, "_out_valid"}, idx, 32'(out_valid), 32'(ov));
    chk({tag, "_out_sum"}, idx, 32'(out_sum), 32'(s));
    chk({tag, "_out_count"}, idx, 32'(out_count), 32'(c));
    chk({tag, "_out_ovf"}, idx, 32'(out_ovf), 32'(f));
  endtask

  task automatic check_out16(input string tag, input int idx, input logic ov,
                             input logic [15:0] s, input logic [4:0] c, input logic f);
    chk({tag, "_out_valid"}, idx, 32'(out_valid2), 32'(ov));
    chk({tag, "_out_sum"}, idx, 32'(out_sum2), 32'(s));
    chk({tag, "_out_count"}, idx, 32'(out_count2), 32'(c));
    chk({tag, "_out_ovf"}, idx, 32'(out_ovf2), 32'(f));
  endtask

  logic [15:0] sat_or_wrap1, sat_or_wrap2;

  initial begin
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    #2;

    //  rst valid prod     last ordy | ir  ov  sum          cnt  ovf
    // Reset held three cycles with in_valid high
    add(1, 1, 16'h1234, 0, 0,   0,  0,  24'h000000,  0,   0);
    add(1, 1, 16'h1234, 0, 0,   0,  0,  24'h000000,  0,   0);
    add(1, 1, 16'h1234, 0, 0,   0,  0,  24'h000000,  0,   0);
    // Basic frame 6 + C + FF = 0x111
    add(0, 1, 16'h0006, 0, 1,   1,  0,  24'h000000,  0,   0);
    add(0, 1, 16'h000C, 0, 1,   1,  0,  24'h000000,  0,   0);
    add(0, 1, 16'h00FF, 1, 1,   1,  1,  24'h000111,  3,   0);
    add(0, 0, 16'h0000, 0, 1,   0,  0,  24'h000111,  3,   0);
    add(0, 0, 16'h0000, 0, 1,   1,  0,  24'h000111,  3,   0);
    // Backpressure: single-product frame, out_ready low for 5 cycles
    add(0, 1, 16'h0005, 1, 0,   1,  1,  24'h000005,  1,   0);
    for (int i = 0; i < 5; i++)
      add(0, 1, 16'h0007, 1, 0, 0,  1,  24'h000005,  1,   0);
    add(0, 1, 16'h0007, 1, 1,   0,  0,  24'h000005,  1,   0);
    add(0, 1, 16'h0007, 1, 1,   1,  1,  24'h000007,  1,   0);
    add(0, 0, 16'h0000, 0, 1,   0,  0,  24'h000007,  1,   0);
    // in_last without in_valid is ignored
    add(0, 0, 16'h0099, 1, 1,   1,  0,  24'h000007,  1,   0);
    // Reset mid-frame discards the partial sum
    add(0, 1, 16'h0010, 0, 1,   1,  0,  24'h000007,  1,   0);
    add(0, 1, 16'h0020, 0, 1,   1,  0,  24'h000007,  1,   0);
    add(1, 1, 16'h0020, 0, 1,   0,  0,  24'h000000,  0,   0);
    add(0, 1, 16'h0003, 1, 1,   1,  1,  24'h000003,  1,   0);
    add(0, 0, 16'h0000, 0, 1,   0,  0,  24'h000003,  1,   0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].prod, vecs[i].last, vecs[i].ordy);
      #1;
      chk("in_ready", i, 32'(in_ready), 32'(vecs[i].exp_ir));
      tick();
      check_out("vec", i, vecs[i].exp_ov, vecs[i].exp_sum, vecs[i].exp_cnt, vecs[i].exp_ovf);
    end

    // NMAX close: 16 x 0xFE01 without in_last
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 16'hFE01, 1'b0, 1'b0);
      #1;
      chk("nmax_in_ready", i, 32'(in_ready), 32'd1);
      tick();
      if (i < 15) chk("nmax_early_valid", i, 32'(out_valid), 32'd0);
    end
    check_out("nmax", 0, 1'b1, 24'h0FE010, 5'd16, 1'b0);
    drive(1'b0, 1'b1, 16'h0001, 1'b0, 1'b1);
    #1;
    chk("nmax_hold_ready", 0, 32'(in_ready), 32'd0);
    tick();
    check_out("nmax_release", 0, 1'b0, 24'h0FE010, 5'd16, 1'b0);

    // NMAX reached together with in_last: one close only
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 16'h0002, (i == 15), 1'b1);
      tick();
    end
    check_out("nmax_last", 0, 1'b1, 24'h000020, 5'd16, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    check_out("nmax_last_release", 0, 1'b0, 24'h000020, 5'd16, 1'b0);
    tick();
    chk("nmax_last_single", 0, 32'(out_valid), 32'd0);

    // Overflow on the AW=16 instance
`ifdef DVSD_PROD_ACC_SAT_EN
    sat_or_wrap1 = 16'hFFFF;
    sat_or_wrap2 = 16'hFFFF;
`else
    sat_or_wrap1 = 16'h0001;
    sat_or_wrap2 = 16'h0004;
`endif
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    check_out16("ovf_reset", 0, 1'b0, 16'h0000, 5'd0, 1'b0);
    drive(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b1, 16'h0002, 1'b1, 1'b1);
    tick();
    check_out16("ovf2", 0, 1'b1, sat_or_wrap1, 5'd2, 1'b1);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    // Three products: sticky ovf and continued wrap/saturation after the carry
    drive(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b1, 16'h0002, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b1, 16'h0003, 1'b1, 1'b1);
    tick();
    check_out16("ovf3", 0, 1'b1, sat_or_wrap2, 5'd3, 1'b1);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    // ovf does not leak into the next frame
    drive(1'b0, 1'b1, 16'h0001, 1'b1, 1'b1);
    tick();
    check_out16("ovf_clear", 0, 1'b1, 16'h0001, 5'd1, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
